// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Width codes follow RISC-V load/store funct3.
package dmem_pkg;

   typedef enum logic [2:0] {
      W_B  = 3'b000,
      W_H  = 3'b001,
      W_W  = 3'b010,
      W_BU = 3'b100,
      W_HU = 3'b101
   } width_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int PROBE_WORD_INDEX = 25;

   function automatic logic width_code_legal(input logic [2:0] w);
      return (w == W_B) || (w == W_H) || (w == W_W) ||
             (w == W_BU) || (w == W_HU);
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane unit: merges store data into the old word
// and extracts/extends load data.
// Ports: width_i (funct3), addr_lo_i (addr[1:0]), wdata_i, old_word_i,
//        store_word_o (merged word), load_data_o (extended load value).
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  logic [2:0]  width_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] old_word_i,
   output logic [31:0] store_word_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = old_word_i[7:0];
      unique case (addr_lo_i)
         2'd0: byte_v = old_word_i[7:0];
         2'd1: byte_v = old_word_i[15:8];
         2'd2: byte_v = old_word_i[23:16];
         2'd3: byte_v = old_word_i[31:24];
         default: byte_v = old_word_i[7:0];
      endcase
      // addr[0] never selects a half; misalignment is judged elsewhere
      half_v = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
   end

   always_comb begin
      load_data_o = '0;
      unique case (width_i)
         W_B:  load_data_o = {{24{byte_v[7]}}, byte_v};
         W_BU: load_data_o = {24'd0, byte_v};
         W_H:  load_data_o = {{16{half_v[15]}}, half_v};
         W_HU: load_data_o = {16'd0, half_v};
         W_W:  load_data_o = old_word_i;
         default: load_data_o = '0;
      endcase
   end

   always_comb begin
      store_word_o = old_word_i;
      unique case (width_i)
         W_B: store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
         W_H: begin
            if (addr_lo_i[1]) store_word_o[31:16] = wdata_i[15:0];
            else              store_word_o[15:0]  = wdata_i[15:0];
         end
         W_W: store_word_o = wdata_i;
         default: store_word_o = old_word_i;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with configurable wait states.
// Ports: clk, reset (async, active-high); request channel req_valid/
// req_ready/req_write/req_width/req_addr/req_wdata; response channel
// rsp_valid/rsp_ready/rsp_rdata/rsp_error; probe_word = word index 25.
// Macro DMEM_ALIGN_CHECK_EN enables misaligned-access errors.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_width,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [31:0] probe_word
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LD =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q;
   logic [2:0]  width_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic        accept, enter_resp;
   logic        cur_wr;
   logic [2:0]  cur_width;
   logic [31:0] cur_addr, cur_wdata;
   logic [AW-1:0] idx;
   logic [31:0] old_word, store_word, load_word;
   logic        in_range, bad_code, bad_store, misalign, err;
   logic        mem_we;

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_error = err_q;

   assign accept = req_ready && req_valid;

   // A zero-wait accept commits on the accept edge, so it must see
   // the live request rather than the capture registers.
   assign cur_wr    = req_ready ? req_write : wr_q;
   assign cur_width = req_ready ? req_width : width_q;
   assign cur_addr  = req_ready ? req_addr  : addr_q;
   assign cur_wdata = req_ready ? req_wdata : wdata_q;

   assign enter_resp = (accept && ZERO_WAIT) ||
                       ((state_q == ST_WAIT) && (cnt_q == 4'd0));

   assign idx      = cur_addr[AW+1:2];
   assign old_word = mem_q[idx];

   assign in_range  = (cur_addr[31:2] < DEPTH_W);
   assign bad_code  = !width_code_legal(cur_width);
   assign bad_store = cur_wr && ((cur_width == W_BU) ||
                                 (cur_width == W_HU));
`ifdef DMEM_ALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      if ((cur_width == W_H) || (cur_width == W_HU))
         misalign = cur_addr[0];
      else if (cur_width == W_W)
         misalign = |cur_addr[1:0];
   end
`else
   assign misalign = 1'b0;
`endif
   assign err    = !in_range || bad_code || bad_store || misalign;
   assign mem_we = enter_resp && cur_wr && !err;

   dmem_lane_unit u_lane (
      .width_i      (cur_width),
      .addr_lo_i    (cur_addr[1:0]),
      .wdata_i      (cur_wdata),
      .old_word_i   (old_word),
      .store_word_o (store_word),
      .load_data_o  (load_word)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (ZERO_WAIT) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (enter_resp) begin
         err_d   = err;
         rdata_d = (err || cur_wr) ? 32'd0 : load_word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         width_q <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else if (accept) begin
         wr_q    <= req_write;
         width_q <= req_width;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Storage is deliberately not reset; a reset forces IDLE, which
   // blocks any commit of a discarded request.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[idx] <= store_word;
   end

   generate
      if (DEPTH_WORDS > PROBE_WORD_INDEX) begin : g_probe
         assign probe_word = mem_q[PROBE_WORD_INDEX];
      end else begin : g_noprobe
         assign probe_word = 32'd0;
      end
   endgenerate

endmodule
